// File: rtl/mem_access_unit.sv
// Load/store unit bridging the EX stage to an AHB-Lite master port.
// Runs one access at a time: misalignment check, address phase, data phase, result pulse.
module mem_access_unit (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_valid_i,
    input  logic        s_ld_i,
    input  logic        s_st_i,
    input  logic [1:0]  s_size_i,
    input  logic        s_unsigned_i,
    input  logic [31:0] s_addr_i,
    input  logic [31:0] s_wdata_i,
    input  logic        s_flush_i,
    output logic [31:0] s_haddr_o,
    output logic [1:0]  s_htrans_o,
    output logic        s_hwrite_o,
    output logic [2:0]  s_hsize_o,
    output logic [31:0] s_hwdata_o,
    input  logic [31:0] s_hrdata_i,
    input  logic        s_hready_i,
    input  logic        s_hresp_i,
    output logic        s_busy_o,
    output logic        s_done_o,
    output logic [31:0] s_rdata_o,
    output logic        s_exc_o,
    output logic [1:0]  s_exc_code_o
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t      state_reg, state_next;
    logic [31:0] haddr_reg;
    logic        hwrite_reg;
    logic [1:0]  size_reg;
    logic        unsigned_reg;
    logic [31:0] wdata_reg;
    logic        flush_seen_reg;
    logic        done_reg;
    logic        exc_reg;
    logic [1:0]  exc_code_reg;
    logic [31:0] rdata_reg;

    logic        accept;
    logic        misaligned;
    logic        complete;
    logic        flushed;
    logic [7:0]  rd_bytes [4];
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_value;
    logic [31:0] hwdata_next;

    assign accept     = (state_reg == IDLE) && s_valid_i && (s_ld_i || s_st_i) && !s_flush_i;
    assign misaligned = ((s_size_i == 2'b01) && s_addr_i[0]) ||
                        ((s_size_i == 2'b10) && (s_addr_i[1:0] != 2'b00));
    assign complete   = (state_reg == DATA) && s_hready_i;
    // A flush arriving on the completing cycle itself must also suppress the pulse.
    assign flushed    = flush_seen_reg || s_flush_i;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign rd_bytes[gi] = s_hrdata_i[8*gi +: 8];
        end
    endgenerate

    assign lane_byte = rd_bytes[haddr_reg[1:0]];
    assign lane_half = haddr_reg[1] ? s_hrdata_i[31:16] : s_hrdata_i[15:0];

    always_comb begin
        load_value = s_hrdata_i;
        case (size_reg)
            2'b00:   load_value = {{24{lane_byte[7] & ~unsigned_reg}}, lane_byte};
            2'b01:   load_value = {{16{lane_half[15] & ~unsigned_reg}}, lane_half};
            default: load_value = s_hrdata_i;
        endcase
    end

    always_comb begin
        hwdata_next = 32'h0;
        if (state_reg == DATA && hwrite_reg) begin
            case (size_reg)
                2'b00:   hwdata_next = {4{wdata_reg[7:0]}};
                2'b01:   hwdata_next = {2{wdata_reg[15:0]}};
                default: hwdata_next = wdata_reg;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && !misaligned) state_next = ADDR;
            ADDR:    if (s_hready_i) state_next = DATA;
            DATA:    if (s_hready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            state_reg      <= IDLE;
            haddr_reg      <= 32'h0;
            hwrite_reg     <= 1'b0;
            size_reg       <= 2'b00;
            unsigned_reg   <= 1'b0;
            wdata_reg      <= 32'h0;
            flush_seen_reg <= 1'b0;
            done_reg       <= 1'b0;
            exc_reg        <= 1'b0;
            exc_code_reg   <= 2'b00;
            rdata_reg      <= 32'h0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            exc_reg   <= 1'b0;
            if (accept) begin
                haddr_reg      <= s_addr_i;
                hwrite_reg     <= s_st_i;
                size_reg       <= s_size_i;
                unsigned_reg   <= s_unsigned_i;
                wdata_reg      <= s_wdata_i;
                flush_seen_reg <= 1'b0;
                if (misaligned) begin
                    exc_reg      <= 1'b1;
                    exc_code_reg <= s_st_i ? 2'b10 : 2'b01;
                end
            end
            if (state_reg != IDLE && s_flush_i)
                flush_seen_reg <= 1'b1;
            if (complete) begin
                flush_seen_reg <= 1'b0;
                if (!flushed) begin
                    if (s_hresp_i) begin
                        exc_reg      <= 1'b1;
                        exc_code_reg <= 2'b11;
                    end else begin
                        done_reg <= 1'b1;
                        if (!hwrite_reg)
                            rdata_reg <= load_value;
                    end
                end
            end
        end
    end

    assign s_haddr_o    = haddr_reg;
    assign s_htrans_o   = (state_reg == ADDR) ? 2'b10 : 2'b00;
    assign s_hwrite_o   = hwrite_reg;
    assign s_hsize_o    = {1'b0, size_reg};
    assign s_hwdata_o   = hwdata_next;
    assign s_busy_o     = (state_reg != IDLE) || (accept && !misaligned);
    assign s_done_o     = done_reg;
    assign s_exc_o      = exc_reg;
    assign s_exc_code_o = exc_code_reg;
    assign s_rdata_o    = rdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model predicts every
// cycle's outputs, and literal checks pin the key results and latencies.
module tb_mem_access_unit;

    logic        s_clk_i = 1'b0;
    logic        s_reset_i;
    logic        s_valid_i, s_ld_i, s_st_i, s_unsigned_i, s_flush_i;
    logic [1:0]  s_size_i;
    logic [31:0] s_addr_i, s_wdata_i;
    logic [31:0] s_haddr_o, s_hwdata_o, s_hrdata_i, s_rdata_o;
    logic [1:0]  s_htrans_o, s_exc_code_o;
    logic        s_hwrite_o, s_hready_i, s_hresp_i, s_busy_o, s_done_o, s_exc_o;
    logic [2:0]  s_hsize_o;

    mem_access_unit dut (
        .s_clk_i(s_clk_i), .s_reset_i(s_reset_i), .s_valid_i(s_valid_i),
        .s_ld_i(s_ld_i), .s_st_i(s_st_i), .s_size_i(s_size_i),
        .s_unsigned_i(s_unsigned_i), .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i),
        .s_flush_i(s_flush_i), .s_haddr_o(s_haddr_o), .s_htrans_o(s_htrans_o),
        .s_hwrite_o(s_hwrite_o), .s_hsize_o(s_hsize_o), .s_hwdata_o(s_hwdata_o),
        .s_hrdata_i(s_hrdata_i), .s_hready_i(s_hready_i), .s_hresp_i(s_hresp_i),
        .s_busy_o(s_busy_o), .s_done_o(s_done_o), .s_rdata_o(s_rdata_o),
        .s_exc_o(s_exc_o), .s_exc_code_o(s_exc_code_o)
    );

    always #5 s_clk_i = ~s_clk_i;

    int cyc = 0;
    always @(posedge s_clk_i) cyc = cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outputs for the current cycle, set by the stimulus from the model
    logic        chk_en = 1'b0;
    logic [1:0]  e_htrans;
    logic        e_busy, e_done, e_exc, e_hwrite;
    logic [1:0]  e_code;
    logic [31:0] e_rdata, e_hwdata, e_haddr;
    logic [2:0]  e_hsize;
    logic [31:0] m_rdata = 32'h0;

    always @(negedge s_clk_i) begin
        if (chk_en) begin
            check("htrans", 32'(s_htrans_o), 32'(e_htrans));
            check("busy",   32'(s_busy_o),   32'(e_busy));
            check("done",   32'(s_done_o),   32'(e_done));
            check("exc",    32'(s_exc_o),    32'(e_exc));
            check("rdata",  s_rdata_o,       e_rdata);
            check("hwdata", s_hwdata_o,      e_hwdata);
            if (e_htrans == 2'b10) begin
                check("haddr",  s_haddr_o,        e_haddr);
                check("hwrite", 32'(s_hwrite_o),  32'(e_hwrite));
                check("hsize",  32'(s_hsize_o),   32'(e_hsize));
            end
            if (e_exc)
                check("exc_code", 32'(s_exc_code_o), 32'(e_code));
        end
    end

    // Observations used by the literal latency checks
    int t0 = 0;
    int done_cyc = -1;
    int exc_cyc = -1;
    int hw_hold = 0;
    always @(negedge s_clk_i) begin
        if (s_done_o) done_cyc = cyc - t0;
        if (s_exc_o) exc_cyc = cyc - t0;
        if (s_hwdata_o == 32'hABCDABCD) hw_hold = hw_hold + 1;
    end

    task automatic set_idle_exp();
        e_htrans = 2'b00; e_busy = 1'b0; e_done = 1'b0; e_exc = 1'b0;
        e_code = 2'b00; e_rdata = m_rdata; e_hwdata = 32'h0;
        e_haddr = 32'h0; e_hwrite = 1'b0; e_hsize = 3'b000;
    endtask

    task automatic step();
        @(posedge s_clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            s_valid_i = 1'b0; s_ld_i = 1'b0; s_st_i = 1'b0; s_flush_i = 1'b0;
            s_hready_i = 1'b1; s_hresp_i = 1'b0;
            set_idle_exp();
            step();
        end
    endtask

    // One complete access: aw/dw wait states in address/data phase, err drives
    // an error response, flush_at = 1-based bus cycle carrying a flush (0 = none).
    task automatic access(input bit st, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int aw, input int dw,
                          input bit err, input int flush_at);
        bit          mis, flushed;
        int          k;
        logic [31:0] rep, res, sh;
        mis = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        case (size)
            2'b00:   rep = {wdata[7:0], wdata[7:0], wdata[7:0], wdata[7:0]};
            2'b01:   rep = {wdata[15:0], wdata[15:0]};
            default: rep = wdata;
        endcase
        case (size)
            2'b00: begin
                sh  = rdata >> (32'(addr[1:0]) * 8);
                res = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                sh  = rdata >> (32'(addr[1]) * 16);
                res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: res = rdata;
        endcase
        flushed = 1'b0;
        k = 0;
        t0 = cyc;
        s_valid_i = 1'b1; s_ld_i = !st; s_st_i = st; s_size_i = size;
        s_unsigned_i = uns; s_addr_i = addr; s_wdata_i = wdata;
        s_flush_i = 1'b0; s_hready_i = 1'b1; s_hresp_i = 1'b0;
        set_idle_exp();
        e_busy = !mis;
        step();
        s_valid_i = 1'b0; s_ld_i = 1'b0; s_st_i = 1'b0;
        if (mis) begin
            set_idle_exp();
            e_exc = 1'b1;
            e_code = st ? 2'b10 : 2'b01;
            step();
            return;
        end
        for (int i = 0; i <= aw; i++) begin
            k++;
            s_hready_i = (i == aw);
            s_flush_i = (k == flush_at);
            if (s_flush_i) flushed = 1'b1;
            set_idle_exp();
            e_htrans = 2'b10; e_busy = 1'b1; e_haddr = addr;
            e_hwrite = st; e_hsize = {1'b0, size};
            step();
        end
        for (int i = 0; i <= dw; i++) begin
            k++;
            s_hready_i = (i == dw);
            s_hresp_i = err;
            s_hrdata_i = (i == dw) ? rdata : 32'h5A5A5A5A;
            s_flush_i = (k == flush_at);
            if (s_flush_i) flushed = 1'b1;
            set_idle_exp();
            e_busy = 1'b1;
            e_hwdata = st ? rep : 32'h0;
            step();
        end
        s_hready_i = 1'b1; s_hresp_i = 1'b0; s_flush_i = 1'b0;
        s_hrdata_i = 32'h0;
        set_idle_exp();
        if (!flushed) begin
            if (err) begin
                e_exc = 1'b1;
                e_code = 2'b11;
            end else begin
                e_done = 1'b1;
                if (!st) m_rdata = res;
            end
        end
        e_rdata = m_rdata;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        s_reset_i = 1'b1; s_valid_i = 1'b0; s_ld_i = 1'b0; s_st_i = 1'b0;
        s_size_i = 2'b00; s_unsigned_i = 1'b0; s_addr_i = 32'h0; s_wdata_i = 32'h0;
        s_flush_i = 1'b0; s_hrdata_i = 32'h0; s_hready_i = 1'b1; s_hresp_i = 1'b0;
        repeat (2) @(posedge s_clk_i);
        #1;
        check("rst_htrans", 32'(s_htrans_o), 32'h0);
        check("rst_haddr", s_haddr_o, 32'h0);
        check("rst_hwdata", s_hwdata_o, 32'h0);
        check("rst_done", 32'(s_done_o), 32'h0);
        check("rst_exc", 32'(s_exc_o), 32'h0);
        check("rst_code", 32'(s_exc_code_o), 32'h0);
        check("rst_rdata", s_rdata_o, 32'h0);
        check("rst_busy", 32'(s_busy_o), 32'h0);
        s_reset_i = 1'b0;
        chk_en = 1'b1;
        idle(3);

        // LW 0x100
        access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0, 0);
        check("lw_rdata_lit", s_rdata_o, 32'hDEADBEEF);
        check("lw_done_cycle", 32'(done_cyc), 32'd3);
        idle(1);
        // LB / LBU at 0x103
        access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80000000, 0, 0, 1'b0, 0);
        check("lb_rdata_lit", s_rdata_o, 32'hFFFFFF80);
        access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80000000, 0, 0, 1'b0, 0);
        check("lbu_rdata_lit", s_rdata_o, 32'h00000080);
        idle(1);
        // SH 0x202 with two data-phase wait states
        hw_hold = 0;
        access(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 0, 2, 1'b0, 0);
        check("sh_hwdata_hold", 32'(hw_hold), 32'd3);
        check("sh_done_cycle", 32'(done_cyc), 32'd5);
        idle(1);
        // Misaligned SW and LH
        access(1'b1, 2'b10, 1'b0, 32'h101, 32'h55, 32'h0, 0, 0, 1'b0, 0);
        check("sw_mis_exc_cycle", 32'(exc_cyc), 32'd1);
        access(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0, 0);
        idle(1);
        // Half loads, byte store, address wait states
        access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80011234, 0, 0, 1'b0, 0);
        check("lh_rdata_lit", s_rdata_o, 32'hFFFF8001);
        access(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h7777F00F, 0, 1, 1'b0, 0);
        access(1'b1, 2'b00, 1'b0, 32'h205, 32'hFFFFFFA5, 32'h0, 1, 0, 1'b0, 0);
        access(1'b0, 2'b00, 1'b0, 32'h201, 32'h0, 32'h00003400, 2, 1, 1'b0, 0);
        check("lb_pos_rdata_lit", s_rdata_o, 32'h00000034);
        access(1'b1, 2'b10, 1'b0, 32'h208, 32'hCAFEF00D, 32'h0, 2, 2, 1'b0, 0);
        idle(1);
        // Bus error on LW
        access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h11111111, 0, 1, 1'b1, 0);
        check("err_rdata_kept", s_rdata_o, 32'h00000034);
        idle(1);
        // Flush in ADDR, flush in DATA: transfers complete silently
        access(1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 32'h22222222, 1, 0, 1'b0, 1);
        access(1'b1, 2'b10, 1'b0, 32'h308, 32'h01020304, 32'h0, 0, 1, 1'b0, 3);
        access(1'b0, 2'b10, 1'b0, 32'h30C, 32'h0, 32'h33333333, 0, 1, 1'b1, 2);
        check("flush_rdata_kept", s_rdata_o, 32'h00000034);
        idle(1);
        // Flush in IDLE blocks acceptance
        s_valid_i = 1'b1; s_ld_i = 1'b1; s_size_i = 2'b10; s_addr_i = 32'h400;
        s_flush_i = 1'b1;
        set_idle_exp();
        step();
        idle(3);

        // Reset asserted in DATA
        s_valid_i = 1'b1; s_ld_i = 1'b1; s_st_i = 1'b0; s_size_i = 2'b10;
        s_addr_i = 32'h500; s_flush_i = 1'b0; s_hready_i = 1'b1;
        set_idle_exp();
        e_busy = 1'b1;
        step();
        s_valid_i = 1'b0; s_ld_i = 1'b0;
        set_idle_exp();
        e_htrans = 2'b10; e_busy = 1'b1; e_haddr = 32'h500; e_hsize = 3'b010;
        step();
        chk_en = 1'b0;
        s_hready_i = 1'b0;
        s_hrdata_i = 32'h99999999;
        #1;
        check("data_busy_pre_rst", 32'(s_busy_o), 32'h1);
        #1;
        s_reset_i = 1'b1;
        #1;
        check("mid_rst_htrans", 32'(s_htrans_o), 32'h0);
        check("mid_rst_busy", 32'(s_busy_o), 32'h0);
        @(posedge s_clk_i);
        #1;
        s_reset_i = 1'b0;
        m_rdata = 32'h0;
        chk_en = 1'b1;
        idle(4);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
